// File: rtl/cla_pkg.sv
// Shared encodings and lookahead helpers for the pipelined carry-lookahead adder.
// Also provides the elaboration guard used to reject invalid width splits.
`ifndef CLA_PKG_MACROS
`define CLA_PKG_MACROS
`define CLA_CHECK_DIV(n, d) if ((n) % (d) != 0) begin : g_div_check $error("cla: bad split"); end
`endif

package cla_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic gp_t gp_bit(input logic a, input logic b);
    gp_t r;
    r.g = a & b;
    r.p = a ^ b;
    return r;
  endfunction

  // Prefix operator: span 'hi' sitting directly above span 'lo'.
  function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

endpackage

// File: rtl/cla_seg.sv
// Combinational adder segment: SEG/SIZE lookahead groups chained by group carry.
// Exposes the carry into its MSB so the last segment can form signed overflow.
module cla_seg
  import cla_pkg::*;
#(
  parameter int unsigned SEG  = 32,
  parameter int unsigned SIZE = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] s,
  output logic           co,
  output logic           c_msb_in
);

  localparam int unsigned GROUPS = SEG / SIZE;

  logic [SEG-1:0] p;
  logic [SEG-1:0] c;

  assign p = a ^ b;

  // Within a group every bit carry is a lookahead from the group carry-in.
  always_comb begin
    logic cg;
    gp_t  run;
    cg  = cin;
    c   = '0;
    run = '{g: 1'b0, p: 1'b1};
    for (int j = 0; j < GROUPS; j++) begin
      run = '{g: 1'b0, p: 1'b1};
      for (int i = 0; i < SIZE; i++) begin
        c[j*SIZE+i] = run.g | (run.p & cg);
        run = gp_combine(gp_bit(a[j*SIZE+i], b[j*SIZE+i]), run);
      end
      cg = run.g | (run.p & cg);
    end
    co = cg;
  end

  assign s        = p ^ c;
  assign c_msb_in = c[SEG-1];

endmodule

// File: rtl/cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready backpressure.
// Each stage adds one SEG-wide slice; the carry crosses stage boundaries in a register.
module cla_pipe
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH  = 128,
  parameter int unsigned SIZE   = 4,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int unsigned SEG = WIDTH / STAGES;

  `CLA_CHECK_DIV(WIDTH, STAGES * SIZE)

  logic advance;

  // Entry k is what stage k consumes: operands shifted so the live slice sits at bit 0,
  // finished sum bits entering from the top so they land aligned after the last stage.
  logic [WIDTH-1:0] a_pipe [STAGES];
  logic [WIDTH-1:0] b_pipe [STAGES];
  logic [WIDTH-1:0] s_pipe [STAGES];
  logic             c_pipe [STAGES];
  logic             v_pipe [STAGES];

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  assign a_pipe[0] = in_a;
  assign b_pipe[0] = (in_op == OP_SUB) ? ~in_b : in_b;
  assign c_pipe[0] = (in_op == OP_SUB) ? 1'b1 : in_cin;
  assign s_pipe[0] = '0;
  assign v_pipe[0] = in_valid;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SEG-1:0]   seg_s;
    logic             seg_co;
    logic             seg_cmsb;
    logic [WIDTH-1:0] s_q;
    logic             c_q;
    logic             v_q;

    cla_seg #(
      .SEG  (SEG),
      .SIZE (SIZE)
    ) u_seg (
      .a        (a_pipe[k][SEG-1:0]),
      .b        (b_pipe[k][SEG-1:0]),
      .cin      (c_pipe[k]),
      .s        (seg_s),
      .co       (seg_co),
      .c_msb_in (seg_cmsb)
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (advance) begin
        v_q <= v_pipe[k];
        c_q <= seg_co;
        s_q <= (s_pipe[k] >> SEG) | (WIDTH'(seg_s) << (WIDTH - SEG));
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= a_pipe[k] >> SEG;
          b_q <= b_pipe[k] >> SEG;
        end
      end

      assign a_pipe[k+1] = a_q;
      assign b_pipe[k+1] = b_q;
      assign s_pipe[k+1] = s_q;
      assign c_pipe[k+1] = c_q;
      assign v_pipe[k+1] = v_q;
    end else begin : g_last
      logic ovf_q;
      // Upper operand bits are all zero by now.
      logic unused_hi;

      assign unused_hi = ^{a_pipe[k], b_pipe[k]};

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= seg_cmsb ^ seg_co;
        end
      end

      assign out_valid = v_q;
      assign out_sum   = s_q;
      assign out_cout  = c_q;
      assign out_ovf   = ovf_q;
    end
  end

endmodule

// File: doc/cla_pipe.md
Name: cla_pipe

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor for the divider datapath.
- Successor to the combinational ripple-of-CLA-groups adder: same group-lookahead arithmetic, split into STAGES registered segments.
- Carry crosses each segment boundary through a register.
- Adds an add/sub mode, a signed overflow flag and a valid/ready handshake with backpressure, so the divider can issue one operation per cycle at high clock rates.

Parameters:
- WIDTH, 128, operand/result width in bits.
- SIZE, 4, bits per CLA group (lookahead unit).
- STAGES, 4, pipeline segments. WIDTH must be divisible by STAGES*SIZE; elaboration error otherwise. SEG = WIDTH/STAGES.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands present
- in_ready  out  1  block accepts operands this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_cin  in  1  carry-in (add mode only)
- in_op  in  1  0 = ADD, 1 = SUB
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_sum  out  WIDTH  A+B+cin, or A-B
- out_cout  out  1  carry-out of MSB (for SUB: 1 = no borrow)
- out_ovf  out  1  signed overflow

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: all stage valid bits 0, out_valid=0, out_sum=0, out_cout=0, out_ovf=0. in_ready=1 in the cycle after reset deasserts.
- Operand preprocessing:
  - ADD: b_eff = in_b, c0 = in_cin.
  - SUB: b_eff = ~in_b, c0 = 1. in_cin is ignored in SUB.
- Stage k (0..STAGES-1):
  - Computes bits [k*SEG +: SEG] with SEG/SIZE CLA groups chained by group carry.
  - Carry-in comes from stage k-1's registered carry (c0 for k=0).
  - Not-yet-consumed upper operand bits are carried forward in the stage register.
  - Already-computed lower sum bits are carried forward unchanged (skew/deskew), so out_sum is aligned.
- Overflow: out_ovf = carry into MSB XOR carry out of MSB, computed in the last stage.
- Latency: exactly STAGES cycles from an accepted input (in_valid && in_ready at edge N) to out_valid=1 after edge N+STAGES-1, with zero stalls.
- Throughput: 1 op/cycle.
- Handshake:
  - Global advance = !out_valid || out_ready. in_ready = advance.
  - When advance=0, every stage register (data and valid) holds.
  - Output fields stay stable while out_valid && !out_ready.
  - Bubbles propagate as valid=0 stages; bubble data is don't-care but must not alter valid data.
- Simultaneous events: output drain and input accept in the same cycle are allowed (full pipe, out_ready=1, in_valid=1 → no bubble).
- Reset mid-operation: all in-flight ops are discarded, valids cleared next edge, no partial result emitted.
- Wrap-around: ADD of all-ones + 1 gives sum=0, cout=1. No saturation.
- STAGES=1: purely one register stage, latency 1.

Decomposition:
- Shared package cla_pkg:
  - op encoding constants OP_ADD=1'b0, OP_SUB=1'b1.
  - Function for group generate/propagate.
  - Elaboration-check macro for divisibility.
- Sub-module cla_seg(SEG, SIZE): combinational segment made of SEG/SIZE lookahead groups. Inputs a, b, cin; outputs s, co, and c_msb_in (carry into its MSB, used for overflow).
- cla_pipe instantiates STAGES cla_seg instances plus the stage registers and handshake.

Test Plan (WIDTH=128, SIZE=4, STAGES=4 unless noted):
1. Reset held 3 cycles, then released with no input → out_valid=0, outputs 0, in_ready=1.
2. ADD a=2^128-1, b=0, cin=1, out_ready=1 → after 4 cycles: sum=0, cout=1, ovf=0. Carry ripples across all 3 stage boundaries.
3. SUB a=5, b=7 → sum=2^128-2, cout=0 (borrow); a=0x8000…0, b=1 → sum=0x7FFF…F, ovf=1.
4. Back-to-back stream of 16 random ops, out_ready=1 → 16 results in order on consecutive cycles, each matching the golden model.
5. Stall: pipe full, out_ready=0 for 5 cycles → in_ready=0, out_* stable. Release → the 4 held results drain in order with no loss or duplication.
6. rst pulsed with 3 ops in flight → no out_valid afterwards. Repeat tests 2–3 with STAGES=1 and WIDTH=32/SIZE=8/STAGES=2.
